regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the single write port of register_file between two writeback sources: ALU and memory.
//   Each source gets a small FIFO with a valid/ready handshake. A round-robin arbiter drains
//   the FIFO heads into registered rf_writeEnable/rf_writeAddr/rf_d outputs.
//   Sits between the EXEC/MEM writeback stages and DECODE's register_file.
// PARAMETERS
//   DATA_W  16  register width
//   ADDR_W  3   register address width (8 registers)
//   DEPTH   2   entries per source FIFO (power of two, >=2)
// PORTS
//   clk            in   1       clock, all state updates on rising edge
//   reset          in   1       asynchronous, active-high; clears all state
//   alu_valid      in   1       ALU write request valid
//   alu_ready      out  1       ALU FIFO not full
//   alu_addr       in   ADDR_W  ALU destination register
//   alu_data       in   DATA_W  ALU result
//   mem_valid      in   1       memory write request valid
//   mem_ready      out  1       memory FIFO not full
//   mem_addr       in   ADDR_W  load destination register
//   mem_data       in   DATA_W  load data
//   rf_writeEnable out  1       to register_file writeEnable (registered)
//   rf_writeAddr   out  ADDR_W  to register_file writeAddr (registered)
//   rf_d           out  DATA_W  to register_file d (registered)
//   busy           out  1       any FIFO non-empty or rf_writeEnable high
// BEHAVIOUR
//   Reset: FIFOs emptied, pending writes discarded, rf_* = 0, busy = 0.
//     alu_ready = mem_ready = 1. Round-robin pointer favours ALU first. Applies mid-operation too.
//   Push: entry accepted at the edge where valid && ready.
//     ready = !full, with no pass-through: a full FIFO does not accept even if popped that cycle.
//   Pop/grant: each cycle, among non-empty heads, pick one.
//     - Only one head non-empty: that head wins.
//     - Both heads non-empty: the source not granted last wins; pointer updates only on a real grant.
//     - The granted head pops at the edge.
//     - At that same edge rf_writeEnable<=1, rf_writeAddr/rf_d <= head.
//     - With no grant, rf_writeEnable<=0 and rf_writeAddr/rf_d hold their values.
//   Latency: push at edge N -> rf_writeEnable high in cycle N+1..N+2 minimum
//     -> register_file writes at edge N+2.
//     An entry pushed into an empty FIFO cannot be granted in the same cycle.
//   Throughput: one write per cycle total. With both sources saturated, each gets every other cycle.
//   Simultaneous push and pop on one FIFO is legal; occupancy is unchanged.
//     Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
//   Ordering: FIFO order is kept within a source. No ordering is kept across sources.
//     WAW between ALU and memory to the same register is resolved by the decode stall logic upstream.
//   Inputs sampled while valid=0 are ignored. Pushing while !ready is a protocol error:
//     the request is dropped, with no state change.
// CONFIGURATION
//   REGFILE_WR_FWD_EN defined: adds inputs fwd_ra, fwd_rb (ADDR_W).
//     Adds outputs fwd_a_hit, fwd_a, fwd_b_hit, fwd_b (1/DATA_W each), all combinational.
//     Hit when any valid FIFO entry, or the output stage with rf_writeEnable=1, targets the address.
//     Data priority on multiple hits:
//       1. memory FIFO, youngest entry first
//       2. ALU FIFO, youngest entry first
//       3. output stage
//     No hit -> hit=0, data=0.
//   Not defined: those ports do not exist; no compare logic is built.
// STRUCTURE
//   regfile_pkg: DATA_W, ADDR_W, NUM_REGS=8 constants.
//     rf_wr_req_t = {addr, data} typedef, shared with register_file and decode.
//   Sub-module wr_fifo (instantiated twice): DEPTH-entry FIFO of rf_wr_req_t.
//     Exposes push/pop/full/empty/head, plus entry-valid/entry vectors for forwarding.
//   Top level holds the arbiter, round-robin pointer, output register and optional forward muxes.
// TESTING
//   1 Reset mid-stream: fill both FIFOs, pulse reset.
//     -> rf_writeEnable=0, busy=0, both ready=1; no write of the old entries ever appears.
//   2 Single ALU push (addr=1, data=16'h0005) at edge N, memory idle.
//     -> rf_writeEnable=1, rf_writeAddr=1, rf_d=16'h0005 in cycle N+1 only.
//   3 Both sources push every cycle with distinct data.
//     -> grants alternate ALU, MEM, ALU, ...; ALU granted first after reset.
//     -> each FIFO's output order equals its push order.
//   4 Hold memory valid with no pops possible (ALU keeps winning alternately), DEPTH=2.
//     -> mem_ready drops after 2 unserved pushes; third request is not accepted until a pop.
//   5 Back-to-back push into an empty ALU FIFO plus simultaneous pop.
//     -> occupancy stays 1; no entry lost or duplicated over 16 cycles.
//   6 (REGFILE_WR_FWD_EN) ALU entry addr 3 = 16'h00AA and MEM entry addr 3 = 16'h00BB both pending,
//     fwd_ra=3 -> fwd_a_hit=1, fwd_a=16'h00BB; fwd_rb=5 -> fwd_b_hit=0, fwd_b=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file constants and the write-request payload shared by
// register_file, decode and the writeback arbiter.
//   NUM_REGS  number of architectural registers
//   DATA_W    register width
//   ADDR_W    register address width
//   rf_wr_req_t  {addr, data} write request
package regfile_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// wr_fifo: DEPTH-entry FIFO of register write requests.
//   clk, reset    clock, asynchronous active-high reset
//   push/push_req enqueue request (ignored while full, no pass-through)
//   pop           dequeue head (ignored while empty)
//   full/empty    occupancy flags
//   head          oldest entry
//   entry_valid/entries  all slots in age order, index 0 = oldest
module wr_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  rf_wr_req_t             push_req,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output rf_wr_req_t             head,
    output logic [DEPTH-1:0]       entry_valid,
    output rf_wr_req_t [DEPTH-1:0] entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rf_wr_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push;
    logic                   do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Age-ordered view of the storage for forwarding lookups.
    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i]     = mem_q[rd_ptr_q + PTR_W'(i)];
            entry_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register_file write port between the ALU and
// memory writeback sources. Each source feeds a wr_fifo; a round-robin arbiter
// drains one head per cycle into the registered rf_* outputs.
//   clk, reset              clock, asynchronous active-high reset
//   alu_valid/ready/addr/data  ALU write request handshake
//   mem_valid/ready/addr/data  memory write request handshake
//   rf_writeEnable/rf_writeAddr/rf_d  registered register_file write port
//   busy                    any FIFO non-empty or a write in the output stage
// Optional: `define REGFILE_WR_FWD_EN adds fwd_ra/fwd_rb lookup inputs and
//   combinational fwd_a_hit/fwd_a/fwd_b_hit/fwd_b outputs.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
`ifdef REGFILE_WR_FWD_EN
    input  logic [ADDR_W-1:0] fwd_ra,
    input  logic [ADDR_W-1:0] fwd_rb,
    output logic              fwd_a_hit,
    output logic [DATA_W-1:0] fwd_a,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_b,
`endif
    output logic              rf_writeEnable,
    output logic [ADDR_W-1:0] rf_writeAddr,
    output logic [DATA_W-1:0] rf_d,
    output logic              busy
);

    rf_wr_req_t             alu_req, mem_req;
    rf_wr_req_t             alu_head, mem_head;
    logic                   alu_full, alu_empty, mem_full, mem_empty;
    logic                   grant_alu, grant_mem;
    logic [DEPTH-1:0]       alu_ent_vld, mem_ent_vld;
    rf_wr_req_t [DEPTH-1:0] alu_ent, mem_ent;

    // rr_last_q = 1 means memory was granted last, so ALU wins the next tie.
    logic              rr_last_q, rr_last_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    assign alu_req.addr = alu_addr;
    assign alu_req.data = alu_data;
    assign mem_req.addr = mem_addr;
    assign mem_req.data = mem_data;

    wr_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (alu_valid),
        .push_req    (alu_req),
        .pop         (grant_alu),
        .full        (alu_full),
        .empty       (alu_empty),
        .head        (alu_head),
        .entry_valid (alu_ent_vld),
        .entries     (alu_ent)
    );

    wr_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (mem_valid),
        .push_req    (mem_req),
        .pop         (grant_mem),
        .full        (mem_full),
        .empty       (mem_empty),
        .head        (mem_head),
        .entry_valid (mem_ent_vld),
        .entries     (mem_ent)
    );

    assign alu_ready      = !alu_full;
    assign mem_ready      = !mem_full;
    assign rf_writeEnable = rf_we_q;
    assign rf_writeAddr   = rf_addr_q;
    assign rf_d           = rf_data_q;
    assign busy           = !alu_empty || !mem_empty || rf_we_q;

    // Round-robin grant and output stage next-state.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        rr_last_d = rr_last_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (!alu_empty && (mem_empty || rr_last_q)) begin
            grant_alu = 1'b1;
            rr_last_d = 1'b0;
            rf_we_d   = 1'b1;
            rf_addr_d = alu_head.addr;
            rf_data_d = alu_head.data;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
            rr_last_d = 1'b1;
            rf_we_d   = 1'b1;
            rf_addr_d = mem_head.addr;
            rf_data_d = mem_head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

`ifdef REGFILE_WR_FWD_EN
    // Later matches override earlier ones, so scan lowest priority first:
    // output stage, then ALU oldest..youngest, then memory oldest..youngest.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [ADDR_W-1:0]       ra,
        input logic                    out_we,
        input logic [ADDR_W-1:0]       out_addr,
        input logic [DATA_W-1:0]       out_data,
        input logic [DEPTH-1:0]        a_vld,
        input rf_wr_req_t [DEPTH-1:0]  a_ent,
        input logic [DEPTH-1:0]        m_vld,
        input rf_wr_req_t [DEPTH-1:0]  m_ent
    );
        logic              hit;
        logic [DATA_W-1:0] val;
        hit = 1'b0;
        val = '0;
        if (out_we && (out_addr == ra)) begin
            hit = 1'b1;
            val = out_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a_vld[i] && (a_ent[i].addr == ra)) begin
                hit = 1'b1;
                val = a_ent[i].data;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && (m_ent[i].addr == ra)) begin
                hit = 1'b1;
                val = m_ent[i].data;
            end
        end
        return {hit, val};
    endfunction

    always_comb begin
        {fwd_a_hit, fwd_a} = fwd_lookup(fwd_ra, rf_we_q, rf_addr_q, rf_data_q,
                                        alu_ent_vld, alu_ent, mem_ent_vld, mem_ent);
        {fwd_b_hit, fwd_b} = fwd_lookup(fwd_rb, rf_we_q, rf_addr_q, rf_data_q,
                                        alu_ent_vld, alu_ent, mem_ent_vld, mem_ent);
    end
`else
    // Entry views only feed forwarding; sink them when that feature is absent.
    logic fwd_unused;
    assign fwd_unused = ^{alu_ent_vld, alu_ent, mem_ent_vld, mem_ent};
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter. ALU requests carry data bit 15 = 0
// and memory requests bit 15 = 1, so each observed write is matched against the
// scoreboard queue of its source.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    typedef logic [ADDR_W+DATA_W-1:0] wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0] alu_addr, mem_addr, rf_writeAddr;
    logic [DATA_W-1:0] alu_data, mem_data, rf_d;
    logic              rf_writeEnable, busy;
`ifdef REGFILE_WR_FWD_EN
    logic [ADDR_W-1:0] fwd_ra, fwd_rb;
    logic              fwd_a_hit, fwd_b_hit;
    logic [DATA_W-1:0] fwd_a, fwd_b;
`endif

    int  checks   = 0;
    int  failures = 0;
    wr_t alu_q[$];
    wr_t mem_q[$];
    int  grant_log[$];
    bit  log_en = 1'b0;
    bit  mon_en = 1'b1;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
`ifdef REGFILE_WR_FWD_EN
        .fwd_ra         (fwd_ra),
        .fwd_rb         (fwd_rb),
        .fwd_a_hit      (fwd_a_hit),
        .fwd_a          (fwd_a),
        .fwd_b_hit      (fwd_b_hit),
        .fwd_b          (fwd_b),
`endif
        .rf_writeEnable (rf_writeEnable),
        .rf_writeAddr   (rf_writeAddr),
        .rf_d           (rf_d),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record accepted requests at the edge where the handshake completes.
    always @(posedge clk) begin
        if (!reset) begin
            if (alu_valid && alu_ready) alu_q.push_back({alu_addr, alu_data});
            if (mem_valid && mem_ready) mem_q.push_back({mem_addr, mem_data});
        end
    end

    // Match each write against the head of its source queue.
    always @(posedge clk) begin
        wr_t obs;
        wr_t exp;
        #1;
        if (mon_en && !reset && rf_writeEnable) begin
            obs = {rf_writeAddr, rf_d};
            if (!rf_d[15]) begin
                if (alu_q.size() == 0) check("wr_alu_unexpected", 32'(rf_writeEnable), 32'd0);
                else begin
                    exp = alu_q.pop_front();
                    check("wr_alu", 32'(obs), 32'(exp));
                    if (log_en) grant_log.push_back(0);
                end
            end else begin
                if (mem_q.size() == 0) check("wr_mem_unexpected", 32'(rf_writeEnable), 32'd0);
                else begin
                    exp = mem_q.pop_front();
                    check("wr_mem", 32'(obs), 32'(exp));
                    if (log_en) grant_log.push_back(1);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        alu_q.delete();
        mem_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_alu(input int seq);
        alu_valid = 1'b1;
        alu_addr  = ADDR_W'(seq);
        alu_data  = {1'b0, 15'(seq)};
    endtask

    task automatic drive_mem(input int seq);
        mem_valid = 1'b1;
        mem_addr  = ADDR_W'(seq + 3);
        mem_data  = {1'b1, 15'(seq)};
    endtask

    initial begin
        bit mr[20];
        bit ar[20];
        bit a_acc, m_acc;
        int a_seq, m_seq;

        reset = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
`ifdef REGFILE_WR_FWD_EN
        fwd_ra = '0; fwd_rb = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_we", 32'(rf_writeEnable), 32'd0);
        check("rst_addr", 32'(rf_writeAddr), 32'd0);
        check("rst_d", 32'(rf_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        reset = 1'b0;

        // Single ALU push: write visible for exactly one cycle after the grant edge.
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0005;
        @(negedge clk);
        alu_valid = 1'b0;
        check("single_we_early", 32'(rf_writeEnable), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_we", 32'(rf_writeEnable), 32'd1);
        check("single_addr", 32'(rf_writeAddr), 32'd1);
        check("single_d", 32'(rf_d), 32'h0005);
        @(negedge clk);
        check("single_we_off", 32'(rf_writeEnable), 32'd0);
        check("single_addr_hold", 32'(rf_writeAddr), 32'd1);
        check("single_d_hold", 32'(rf_d), 32'h0005);
        check("single_busy_off", 32'(busy), 32'd0);

        // Both sources saturated: alternating grants and backpressure pattern.
        do_reset();
        grant_log.delete();
        log_en = 1'b1;
        a_seq = 100; m_seq = 200;
        for (int k = 0; k < 20; k++) begin
            drive_alu(a_seq);
            drive_mem(m_seq);
            ar[k] = alu_ready; mr[k] = mem_ready;
            a_acc = alu_ready; m_acc = mem_ready;
            @(negedge clk);
            if (a_acc) a_seq++;
            if (m_acc) m_seq++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (10) @(negedge clk);
        log_en = 1'b0;
        check("sat_mem_ready0", 32'(mr[0]), 32'd1);
        check("sat_mem_ready1", 32'(mr[1]), 32'd1);
        check("sat_mem_ready2", 32'(mr[2]), 32'd0);
        check("sat_mem_ready3", 32'(mr[3]), 32'd1);
        check("sat_mem_ready4", 32'(mr[4]), 32'd0);
        check("sat_alu_ready3", 32'(ar[3]), 32'd0);
        check("sat_alu_ready4", 32'(ar[4]), 32'd1);
        check("sat_grant_cnt", 32'(grant_log.size() >= 16), 32'd1);
        for (int i = 0; i < 16 && i < grant_log.size(); i++)
            check("sat_grant_seq", 32'(grant_log[i]), 32'(i % 2));
        check("sat_alu_drained", 32'(alu_q.size()), 32'd0);
        check("sat_mem_drained", 32'(mem_q.size()), 32'd0);

        // Reset mid-stream: queued entries must never reach the write port.
        a_seq = 300; m_seq = 400;
        for (int k = 0; k < 4; k++) begin
            drive_alu(a_seq + k);
            drive_mem(m_seq + k);
            @(negedge clk);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b1;
        alu_q.delete(); mem_q.delete();
        #1;
        check("midrst_we", 32'(rf_writeEnable), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_ready", 32'(alu_ready), 32'd1);
        check("midrst_mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_no_write", 32'(rf_writeEnable), 32'd0);
        end

        // ALU streaming into an empty FIFO: push and pop every cycle, occupancy 1.
        a_seq = 500;
        for (int k = 0; k < 16; k++) begin
            drive_alu(a_seq + k);
            @(negedge clk);
            check("stream_alu_ready", 32'(alu_ready), 32'd1);
            if (k >= 1) check("stream_we", 32'(rf_writeEnable), 32'd1);
        end
        alu_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_busy_off", 32'(busy), 32'd0);
        check("stream_alu_drained", 32'(alu_q.size()), 32'd0);

`ifdef REGFILE_WR_FWD_EN
        // Forwarding: memory entry wins over ALU entry for the same register.
        mon_en = 1'b0;
        do_reset();
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h00AA;
        mem_valid = 1'b1; mem_addr = 3'd3; mem_data = 16'h00BB;
        fwd_ra = 3'd3; fwd_rb = 3'd5;
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("fwd_a_hit", 32'(fwd_a_hit), 32'd1);
        check("fwd_a", 32'(fwd_a), 32'h00BB);
        check("fwd_b_hit", 32'(fwd_b_hit), 32'd0);
        check("fwd_b", 32'(fwd_b), 32'd0);
        repeat (4) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
